// File: rtl/orb_word_packer.sv
`timescale 1ns/1ps
// Packs a low/high byte pair from a strobed telemetry group into one orbit word per matched channel.
// Latency: WE rises WE_DELAY+1 cycles after the qualifying high-byte word; no backpressure, strobes during a write window are ignored.
// Build option ORB_PARITY_EN puts odd parity in orbWord bit 0 (otherwise bit 0 is 0).
module orb_word_packer #(
    parameter int DATA_W    = 8,
    parameter int WORD_W    = 12,
    parameter int HI_BITS   = 2,
    parameter int ADDR_W    = 11,
    parameter int GROUP_LEN = 18,
    parameter int LO_IDX    = 16,
    parameter int HI_IDX    = 17,
    parameter int NCH       = 4,
    parameter int BASE_ADDR = 479,
    parameter int ADDR_STEP = 1,
    parameter int STB_QUAL  = 4,
    parameter int WE_DELAY  = 28,
    parameter int WE_HOLD   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] iData,
    input  logic [ADDR_W-1:0] addrRam,
    input  logic              strob,
    input  logic              SW,
    input  logic [NCH-1:0]    chEn,
    output logic              test,
    output logic [WORD_W-1:0] orbWord,
    output logic              WE,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [7:0]        dropCnt
);
    localparam int WC_W = (GROUP_LEN > 1) ? $clog2(GROUP_LEN) : 1;
    localparam int Q_W  = (STB_QUAL > 1) ? $clog2(STB_QUAL) : 1;
    localparam int T_W  = $clog2(WE_DELAY + WE_HOLD + 1);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, EVAL, WDELAY, WAIT} state_t;

    state_t            state, state_n;
    logic [Q_W-1:0]    qual, qual_n;
    logic [WC_W-1:0]   wcnt, wcnt_n;
    logic [T_W-1:0]    tcnt, tcnt_n;
    logic [DATA_W-1:0] lo_q, lo_n;
    logic [CH_W-1:0]   lo_ch, lo_ch_n;
    logic              lo_vld, lo_vld_n;
    logic [WORD_W-1:0] word_n;
    logic              we_n, test_n;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        drop_n;
    logic              drop_inc;

    logic strob_m, strob_s, sw_m, sw_s, sw_d, sw_edge;
    logic              hit;
    logic [CH_W-1:0]   hit_ch;
    logic              par_bit;
    logic [WORD_W-1:0] pack_word;

    // Plain synchronisers; sw_d keeps the previous synced level for edge detection
    always_ff @(posedge clk) begin
        strob_m <= strob;
        strob_s <= strob_m;
        sw_m    <= SW;
        sw_s    <= sw_m;
        sw_d    <= sw_s;
    end
    assign sw_edge = sw_s ^ sw_d;

    always_comb begin
        hit    = 1'b0;
        hit_ch = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!hit && chEn[k] && addrRam == ADDR_W'(BASE_ADDR + k * ADDR_STEP)) begin
                hit    = 1'b1;
                hit_ch = CH_W'(k);
            end
        end
    end

`ifdef ORB_PARITY_EN
    assign par_bit = ~(^{iData[HI_BITS-1:0], lo_q});
`else
    assign par_bit = 1'b0;
`endif
    assign pack_word = {1'b0, iData[HI_BITS-1:0], lo_q, par_bit};

    always_comb begin
        state_n  = state;
        qual_n   = qual;
        wcnt_n   = wcnt;
        tcnt_n   = tcnt;
        lo_n     = lo_q;
        lo_ch_n  = lo_ch;
        lo_vld_n = lo_vld;
        word_n   = orbWord;
        we_n     = WE;
        addr_n   = WrAddr;
        drop_n   = dropCnt;
        test_n   = sw_edge;
        drop_inc = 1'b0;
        case (state)
            IDLE: begin
                if (!strob_s) begin
                    qual_n = '0;
                end else if (qual == Q_W'(STB_QUAL - 1)) begin
                    qual_n  = '0;
                    state_n = EVAL;
                end else begin
                    qual_n = qual + 1'b1;
                end
            end
            EVAL: begin
                state_n = WAIT;
                wcnt_n  = (wcnt == WC_W'(GROUP_LEN - 1)) ? '0 : wcnt + 1'b1;
                if (wcnt == WC_W'(LO_IDX) && hit) begin
                    lo_n     = iData;
                    lo_ch_n  = hit_ch;
                    lo_vld_n = 1'b1;
                end
                if (wcnt == WC_W'(HI_IDX)) begin
                    lo_vld_n = 1'b0;
                    if (hit && lo_vld && lo_ch == hit_ch) begin
                        word_n  = pack_word;
                        addr_n  = addrRam;
                        tcnt_n  = '0;
                        state_n = WDELAY;
                    end else if (hit) begin
                        drop_inc = 1'b1;
                    end
                end
            end
            WDELAY: begin
                tcnt_n = tcnt + 1'b1;
                // Registered one count early so WE is visible while tcnt == WE_DELAY
                if (tcnt == T_W'(WE_DELAY - 1))
                    we_n = 1'b1;
                if (tcnt == T_W'(WE_DELAY + WE_HOLD)) begin
                    tcnt_n  = '0;
                    state_n = WAIT;
                end
            end
            default: begin
                if (!strob_s) begin
                    we_n    = 1'b0;
                    addr_n  = '0;
                    state_n = IDLE;
                end
            end
        endcase
        // A frame switch overrides whatever the current word was doing
        if (sw_edge) begin
            wcnt_n   = '0;
            lo_vld_n = 1'b0;
            tcnt_n   = '0;
            if (state == EVAL) begin
                state_n  = WAIT;
                word_n   = orbWord;
                addr_n   = WrAddr;
                lo_n     = lo_q;
                lo_ch_n  = lo_ch;
                drop_inc = 1'b0;
            end else if (state == WDELAY) begin
                state_n = WAIT;
                if (!WE) begin
                    we_n     = 1'b0;
                    drop_inc = 1'b1;
                end
            end
        end
        if (drop_inc && dropCnt != 8'hFF)
            drop_n = dropCnt + 8'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            qual    <= '0;
            wcnt    <= '0;
            tcnt    <= '0;
            lo_q    <= '0;
            lo_ch   <= '0;
            lo_vld  <= 1'b0;
            orbWord <= '0;
            WE      <= 1'b0;
            WrAddr  <= '0;
            dropCnt <= '0;
            test    <= 1'b0;
        end else begin
            state   <= state_n;
            qual    <= qual_n;
            wcnt    <= wcnt_n;
            tcnt    <= tcnt_n;
            lo_q    <= lo_n;
            lo_ch   <= lo_ch_n;
            lo_vld  <= lo_vld_n;
            orbWord <= word_n;
            WE      <= we_n;
            WrAddr  <= addr_n;
            dropCnt <= drop_n;
            test    <= test_n;
        end
    end
endmodule
